// File: rtl/led_matrix_scanner_pkg.sv
// Shared definitions for the LED matrix scanner and the logic that produces its images.
// A pixel's bit position in a frame is given by pix_idx().
package led_matrix_scanner_pkg;

    localparam int MATRIX_ROWS = 6;
    localparam int MATRIX_COLS = 6;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    function automatic int pix_idx(input int r, input int c, input int cols = MATRIX_COLS);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// Double-buffered frame store. The handshake fills the shadow buffer, and the
// display buffer is updated only when the scan wraps, so an image never tears.
module led_frame_buffer #(
    parameter int PIXELS = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PIXELS-1:0] img_in,
    input  logic              img_valid,
    output logic              img_ready,
    input  logic              wrap,
    output logic [PIXELS-1:0] display
);

    logic [PIXELS-1:0] shadow;
    logic              pending;

    assign img_ready = !pending;

    // NOTE: both image buffers are reset on purpose, so a reset blanks the panel and drops any queued frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            display <= '0;
            pending <= 1'b0;
        end else if (img_valid && img_ready) begin
            shadow  <= img_in;
            pending <= 1'b1;
        end else if (wrap && pending) begin
            display <= shadow;
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed scan of the LED matrix. Each row is blanked first and then
// driven for a fixed dwell; row and col are registered straight off the scan FSM.
module led_matrix_scanner
    import led_matrix_scanner_pkg::*;
#(
    parameter int ROWS         = MATRIX_ROWS,
    parameter int COLS         = MATRIX_COLS,
    parameter int DWELL_CYCLES = 2000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS*COLS-1:0] img_in,
    input  logic                 img_valid,
    output logic                 img_ready,
    output logic                 frame_start,
    output logic [ROWS-1:0]      row,
    output logic [COLS-1:0]      col
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    scan_state_t          state, state_nxt;
    logic [CW-1:0]        counter, counter_nxt;
    logic [RW-1:0]        row_idx, row_idx_nxt;
    logic [ROWS-1:0]      row_nxt;
    logic [COLS-1:0]      col_nxt;
    logic                 frame_start_nxt;
    logic                 wrap;
    logic [ROWS*COLS-1:0] display;

    led_frame_buffer #(
        .PIXELS (ROWS * COLS)
    ) u_frame_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .img_in    (img_in),
        .img_valid (img_valid),
        .img_ready (img_ready),
        .wrap      (wrap),
        .display   (display)
    );

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt       = state;
        counter_nxt     = counter + 1'b1;
        row_idx_nxt     = row_idx;
        row_nxt         = row;
        col_nxt         = col;
        frame_start_nxt = 1'b0;
        wrap            = 1'b0;
        case (state)
            ST_BLANK: begin
                if (counter == BLANK_LAST) begin
                    state_nxt       = ST_DRIVE;
                    counter_nxt     = '0;
                    row_nxt         = ROWS'(1) << row_idx;
                    frame_start_nxt = (row_idx == '0);
                    for (int c = 0; c < COLS; c++) begin
                        col_nxt[c] = ~display[PW'(pix_idx(int'(row_idx), c, COLS))];
                    end
                end
            end
            ST_DRIVE: begin
                if (counter == DWELL_LAST) begin
                    state_nxt   = ST_BLANK;
                    counter_nxt = '0;
                    row_nxt     = '0;
                    col_nxt     = '1;
                    // The last row's exit is the frame boundary where a pending image is swapped in.
                    if (row_idx == ROW_LAST) begin
                        row_idx_nxt = '0;
                        wrap        = 1'b1;
                    end else begin
                        row_idx_nxt = row_idx + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_BLANK;
        endcase
    end

    // NOTE: state registers use non-blocking assignments, so every flop samples values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BLANK;
            counter     <= '0;
            row_idx     <= '0;
            row         <= '0;
            col         <= '1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            counter     <= counter_nxt;
            row_idx     <= row_idx_nxt;
            row         <= row_nxt;
            col         <= col_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner: a frame-level reference model queues the
// expected outputs for each cycle, and a monitor compares them at the falling edge.
module tb_led_matrix_scanner;

    localparam int ROWS  = 6;
    localparam int COLS  = 6;
    localparam int NPIX  = ROWS * COLS;
    localparam int BLANK = 2;
    localparam int DWELL = 4;
    localparam int SLOT  = BLANK + DWELL;
    localparam int P     = ROWS * SLOT;

    typedef struct packed {
        logic [ROWS-1:0] row;
        logic [COLS-1:0] col;
        logic            fs;
        logic            ready;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NPIX-1:0] img_in = '0;
    logic            img_valid = 1'b0;
    logic            img_ready;
    logic            frame_start;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;

    logic            rst_n_def = 1'b0;
    logic [NPIX-1:0] img_in_def = '0;
    logic            img_valid_def = 1'b0;
    logic            img_ready_def;
    logic            fs_def;
    logic [ROWS-1:0] row_def;
    logic [COLS-1:0] col_def;

    int total = 0;
    int bad   = 0;
    bit def_done = 1'b0;

    exp_t exp_q[$];

    int              m_n = 0;
    logic [NPIX-1:0] m_shadow = '0;
    logic [NPIX-1:0] m_disp = '0;
    bit              m_pend = 1'b0;

    always #5 clk = ~clk;

    led_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .img_in(img_in), .img_valid(img_valid),
        .img_ready(img_ready), .frame_start(frame_start), .row(row), .col(col)
    );

    led_matrix_scanner dut_def (
        .clk(clk), .rst_n(rst_n_def), .img_in(img_in_def), .img_valid(img_valid_def),
        .img_ready(img_ready_def), .frame_start(fs_def), .row(row_def), .col(col_def)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Expected outputs after n clock edges since reset release.
    function automatic exp_t expected(input int n);
        exp_t e;
        int   p, r, ph;
        p  = n % P;
        r  = p / SLOT;
        ph = p % SLOT;
        e.ready = !m_pend;
        e.fs    = (r == 0) && (ph == BLANK);
        if (ph < BLANK) begin
            e.row = '0;
            e.col = '1;
        end else begin
            e.row = ROWS'(1) << r;
            for (int c = 0; c < COLS; c++) e.col[c] = ~m_disp[r * COLS + c];
        end
        return e;
    endfunction

    task automatic model_step();
        bit acc, swp;
        if (!rst_n) begin
            m_n = 0; m_shadow = '0; m_disp = '0; m_pend = 1'b0;
        end else begin
            m_n++;
            acc = img_valid && !m_pend;
            swp = (m_n % P == 0) && m_pend;
            if (swp) begin m_disp = m_shadow; m_pend = 1'b0; end
            if (acc) begin m_shadow = img_in; m_pend = 1'b1; end
        end
        exp_q.push_back(expected(m_n));
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge rst_n);
        exp_q.delete();
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("row", 64'(row), 64'(e.row));
                check("col", 64'(col), 64'(e.col));
                check("frame_start", 64'(frame_start), 64'(e.fs));
                check("img_ready", 64'(img_ready), 64'(e.ready));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NPIX-1:0] img, input int cycles);
        img_valid = 1'b1;
        img_in    = img;
        tick(cycles);
        img_valid = 1'b0;
    endtask

    task automatic measure_default();
        int cyc, period;
        repeat (3) @(posedge clk);
        #1 rst_n_def = 1'b1;
        check("default_ready", 64'(img_ready_def), 64'd1);
        cyc = 0;
        while (!fs_def && cyc < 20000) begin @(negedge clk); cyc++; end
        period = 0;
        if (fs_def) begin
            @(negedge clk);
            period = 1;
            while (!fs_def && period < 20000) begin @(negedge clk); period++; end
        end
        check("default_frame_period", 64'(period), 64'(6 * (16 + 2000)));
        def_done = 1'b1;
    endtask

    initial begin : stimulus
        int guard;
        fork measure_default(); join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick(1);

        // Idle scan with a blank display.
        tick(2 * P);

        // Single pixel at row 1, col 1.
        send(NPIX'(1) << 7, 1);
        tick(3 * P);

        // A second frame offered while the first is pending.
        send({NPIX{1'b0}} | NPIX'(36'h5_A5A5_A5A5), 1);
        send({NPIX{1'b1}}, 3 * P);
        tick(2 * P);

        // Accept exactly on the wrap cycle with nothing pending.
        guard = 0;
        while ((m_pend || (m_n % P != P - 1)) && guard < 4 * P) begin tick(1); guard++; end
        check("wrap_align", 64'(m_n % P), 64'(P - 1));
        send(NPIX'(36'hC_3C3C_3C3C), 1);
        tick(3 * P);

        // Random frames and gaps.
        for (int i = 0; i < 8; i++) begin
            tick($urandom_range(0, 50));
            send({4'($urandom), $urandom}, $urandom_range(1, 3));
        end
        tick(3 * P);

        // Light the whole panel, then reset in the middle of row 3's drive.
        send({NPIX{1'b1}}, 1);
        tick(2 * P + 2);
        guard = 0;
        while ((m_n % P != 3 * SLOT + BLANK + 1) && guard < 2 * P) begin tick(1); guard++; end
        @(negedge clk);
        #1;
        check("pre_reset_row", 64'(row), 64'(6'b001000));
        check("pre_reset_col", 64'(col), 64'(6'b000000));
        rst_n = 1'b0;
        #1;
        check("async_row", 64'(row), 64'd0);
        check("async_col", 64'(col), 64'(6'b111111));
        check("async_fs", 64'(frame_start), 64'd0);
        check("async_ready", 64'(img_ready), 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick(2 * P + 3);

        guard = 0;
        while (!def_done && guard < 30000) begin @(posedge clk); guard++; end
        check("default_done", 64'(def_done), 64'd1);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
